decoder_scan_ctrl: RTL and testbench
====================================

Name: decoder_scan_ctrl

Overview:
- Sequencer for the 3-to-8 decoder: generates the 3-bit select {in1,in2,in3} (in1 = MSB) so the decoder output walks through its 8 lines.
- Each line is held for a programmable dwell time.
- Supports start/stop control, scan direction, and a handshaked jump to an arbitrary channel.
- Sits between user control logic (keys/host) and the decoder3_8 instance; outputs connect directly to the decoder inputs.

Parameters:
- CNT_MAX, 24'd9_999_999, dwell length minus 1, in sys_clk cycles (default 0.2 s at 50 MHz). Each channel is held CNT_MAX+1 cycles.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse, begin scanning
- stop  input  1  one-cycle pulse, halt scanning
- dir  input  1  0 = ascending (0→7), 1 = descending (7→0); sampled at each step
- jump_req  input  1  level request to load jump_ch
- jump_ch  input  3  target channel for jump
- jump_ack  output  1  one-cycle acknowledge of jump_req
- in1  output  1  decoder select bit 2 (MSB)
- in2  output  1  decoder select bit 1
- in3  output  1  decoder select bit 0
- busy  output  1  high while in RUN
- wrap  output  1  one-cycle pulse on 7→0 (asc) or 0→7 (desc) step

Behaviour:
- Reset is synchronous and active-low on sys_clk. While sys_rst_n = 0 at an edge:
  - state = IDLE, sel = 3'd0, cnt = 0;
  - busy = 0, wrap = 0, jump_ack = 0.
  - Reset mid-scan aborts immediately; no pending step survives.
- All outputs are registered. {in1,in2,in3} = sel.
- State IDLE:
  - sel held, cnt = 0.
  - start = 1 → RUN, cnt ← 0, busy = 1 from the next cycle.
  - stop ignored.
- State RUN:
  - cnt increments by 1 per cycle.
  - When cnt == CNT_MAX: cnt ← 0 and sel ← sel+1 (dir = 0) or sel−1 (dir = 1), modulo 8.
  - wrap = 1 in the same cycle the new sel appears, only when the step crosses 7↔0 in the active direction; otherwise wrap = 0.
  - start ignored (no restart).
  - stop = 1 → IDLE next edge, cnt ← 0, sel held, busy ← 0, no step that cycle.
- Timing: with start sampled at edge k, first step appears after edge k+CNT_MAX+1; later steps follow every CNT_MAX+1 cycles.
- Jump (any state):
  - jump_req = 1 at an edge with no stop → sel ← jump_ch, cnt ← 0, jump_ack = 1 for that one cycle.
  - State is unchanged: RUN continues with a full dwell on the new channel; IDLE stays idle on the new channel.
  - Requester drops jump_req on seeing jump_ack. If jump_req is still high the following cycle, it is a new request and is acked again.
- Priority within one cycle: reset > stop > jump > step > start.
  - stop + jump_req: stop taken, no ack.
  - jump + terminal count: jump taken, no step, wrap = 0.
  - start + stop in IDLE: stays IDLE.
- CNT_MAX = 0: sel steps every cycle in RUN.
- dir may change at any time; it only affects the next step.

Test Plan:
- CNT_MAX = 3 for all scenarios.
- Reset/idle: assert sys_rst_n = 0 for 3 cycles, release, hold 20 cycles with no start → sel = 0, busy = 0, wrap = 0, jump_ack = 0 throughout.
- Ascending scan: start pulse at edge k → busy = 1 after k; sel = 1 after edge k+4, 2 after k+8 … 7 after k+28, 0 after k+32 with wrap = 1 for exactly that cycle.
- Descending scan: dir = 1, start → sel goes 0→7 after 4 cycles with wrap = 1, then 6, 5 every 4 cycles. Flip dir to 0 mid-dwell → next step is +1.
- Stop/restart: stop at sel = 5, cnt = 2 → busy = 0 next cycle, sel stays 5 for 10+ cycles. start → sel = 6 exactly 4 cycles later.
- Jump: in RUN at sel = 2, cnt = 3, dir = 0, assert jump_req with jump_ch = 6 → sel = 6 (not 3), jump_ack = 1 one cycle, next step to 7 after 4 more cycles. Jump in IDLE to 4 → sel = 4, busy stays 0.
- Collisions: stop + jump_req same cycle → IDLE, sel unchanged, jump_ack = 0. sys_rst_n = 0 during RUN at sel = 6 → sel = 0, busy = 0 next edge.

Source files
------------

// File: rtl/decoder_scan_ctrl.sv
// ----------------------------------------------------------------------------
// decoder_scan_ctrl
//
// Drives the 3-bit select {in1,in2,in3} of a 3-to-8 decoder so its active
// output walks through all 8 lines. Each line is held for CNT_MAX+1 cycles.
// Scanning can be started and stopped, run in either direction, and
// redirected to any channel through a jump request/acknowledge handshake.
//
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   synchronous active-low reset
//   start      in   one-cycle pulse: begin scanning (ignored while running)
//   stop       in   one-cycle pulse: halt scanning, select held
//   dir        in   0 = ascending, 1 = descending, sampled at each step
//   jump_req   in   level request to load jump_ch into the select
//   jump_ch    in   target channel for a jump
//   jump_ack   out  one-cycle acknowledge of an accepted jump
//   in1..in3   out  decoder select, in1 = MSB
//   busy       out  high while scanning
//   wrap       out  one-cycle pulse when a step crosses 7<->0
//   dbg_state  out  current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: jump_req is sampled on every rising edge. An edge where
// jump_req = 1 and stop = 0 accepts the request; jump_ack is high for the
// following cycle only. A requester still holding jump_req in that cycle
// issues a second, independent request.
// ----------------------------------------------------------------------------
module decoder_scan_ctrl #(
  parameter logic [23:0] CNT_MAX = 24'd9_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       jump_req,
  input  logic [2:0] jump_ch,
  output logic       jump_ack,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       wrap,
  output logic [0:0] dbg_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_q,    state_d;
  logic [2:0]  sel_q,      sel_d;
  logic [23:0] cnt_q,      cnt_d;
  logic        busy_q,     busy_d;
  logic        wrap_q,     wrap_d;
  logic        jump_ack_q, jump_ack_d;

  // Priority inside a cycle: stop > jump > step > start.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    jump_ack_d = 1'b0;

    if (stop) begin
      // Stop also blocks a jump in the same cycle, even when idle.
      state_d = ST_IDLE;
      cnt_d   = 24'd0;
    end else if (jump_req) begin
      // The jump replaces any step due this cycle and restarts the dwell.
      sel_d      = jump_ch;
      cnt_d      = 24'd0;
      jump_ack_d = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = 24'd0;
        if (dir) begin
          sel_d  = sel_q - 3'd1;
          wrap_d = (sel_q == 3'd0);
        end else begin
          sel_d  = sel_q + 3'd1;
          wrap_d = (sel_q == 3'd7);
        end
      end else begin
        cnt_d = cnt_q + 24'd1;
      end
    end else if (start) begin
      state_d = ST_RUN;
      cnt_d   = 24'd0;
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 3'd0;
      cnt_q      <= 24'd0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      jump_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      wrap_q     <= wrap_d;
      jump_ack_q <= jump_ack_d;
    end
  end

  assign in1       = sel_q[2];
  assign in2       = sel_q[1];
  assign in3       = sel_q[0];
  assign busy      = busy_q;
  assign wrap      = wrap_q;
  assign jump_ack  = jump_ack_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
module tb_decoder_scan_ctrl;

  localparam int CNT_MAX = 3;
  localparam int DWELL   = CNT_MAX + 1;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       start;
  logic       stop;
  logic       dir;
  logic       jump_req;
  logic [2:0] jump_ch;
  logic       jump_ack;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       busy;
  logic       wrap;
  logic [0:0] dbg_state;

  int total;
  int bad;

  // Expected {sel[2:0], busy, wrap, jump_ack}
  logic [5:0] exp_q[$];

  // Behavioural reference: running flag, channel, cycles spent on channel.
  bit m_run;
  int m_sel;
  int m_age;
  bit m_wrap;
  bit m_ack;

  decoder_scan_ctrl #(.CNT_MAX(24'(CNT_MAX))) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .jump_req  (jump_req),
    .jump_ch   (jump_ch),
    .jump_ack  (jump_ack),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .busy      (busy),
    .wrap      (wrap),
    .dbg_state (dbg_state)
  );

  // clock
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model applied at each rising edge, using the inputs held there.
  task automatic model_edge();
    if (!sys_rst_n) begin
      m_run = 0; m_sel = 0; m_age = 0; m_wrap = 0; m_ack = 0;
    end else begin
      m_wrap = 0;
      m_ack  = 0;
      if (stop) begin
        m_run = 0;
        m_age = 0;
      end else if (jump_req) begin
        m_sel = int'(jump_ch);
        m_age = 0;
        m_ack = 1;
      end else if (m_run) begin
        m_age = m_age + 1;
        if (m_age == DWELL) begin
          m_age = 0;
          if (dir) begin
            m_wrap = (m_sel == 0);
            m_sel  = (m_sel + 7) % 8;
          end else begin
            m_wrap = (m_sel == 7);
            m_sel  = (m_sel + 1) % 8;
          end
        end
      end else if (start) begin
        m_run = 1;
        m_age = 0;
      end
    end
  endtask

  // driver: apply inputs, clock one edge, score the outputs 1 time unit later
  task automatic tick(input logic st, input logic sp, input logic jr, input logic [2:0] jc);
    logic [5:0] e;
    start = st; stop = sp; jump_req = jr; jump_ch = jc;
    @(posedge sys_clk);
    model_edge();
    exp_q.push_back({3'(m_sel), m_run, m_wrap, m_ack});
    #1;
    start = 1'b0; stop = 1'b0; jump_req = 1'b0;
    e = exp_q.pop_front();
    chk("sel",      {in1, in2, in3},       e[5:3]);
    chk("busy",     {2'b00, busy},         {2'b00, e[2]});
    chk("wrap",     {2'b00, wrap},         {2'b00, e[1]});
    chk("jump_ack", {2'b00, jump_ack},     {2'b00, e[0]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    m_run = 0; m_sel = 0; m_age = 0; m_wrap = 0; m_ack = 0;
    sys_rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0;
    jump_req = 1'b0; jump_ch = 3'd0;

    // Reset then stay idle with no start
    idle(3);
    sys_rst_n = 1'b1;
    idle(20);
    chk("idle_sel",  {in1, in2, in3}, 3'd0);
    chk("idle_busy", {2'b00, busy},   3'd0);

    // Ascending scan, wrap on 7->0
    dir = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 3'd0);
    chk("asc_busy", {2'b00, busy}, 3'd1);
    for (int i = 1; i <= 32; i++) begin
      tick(1'b0, 1'b0, 1'b0, 3'd0);
      if (i % 4 == 0) begin
        chk("asc_sel",  {in1, in2, in3}, 3'(i / 4));
        chk("asc_wrap", {2'b00, wrap},   (i == 32) ? 3'd1 : 3'd0);
      end
    end
    tick(1'b0, 1'b1, 1'b0, 3'd0);

    // Descending scan, then flip direction mid-dwell
    dir = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 3'd0);
    idle(4);
    chk("desc_sel7",  {in1, in2, in3}, 3'd7);
    chk("desc_wrap",  {2'b00, wrap},   3'd1);
    idle(4);
    chk("desc_sel6",  {in1, in2, in3}, 3'd6);
    idle(4);
    chk("desc_sel5",  {in1, in2, in3}, 3'd5);
    idle(2);
    dir = 1'b0;
    idle(2);
    chk("flip_sel6",  {in1, in2, in3}, 3'd6);

    // Stop at sel=5, cnt=2, then restart
    tick(1'b0, 1'b0, 1'b1, 3'd5);
    idle(2);
    tick(1'b0, 1'b1, 1'b0, 3'd0);
    chk("stop_busy", {2'b00, busy}, 3'd0);
    idle(12);
    chk("stop_hold", {in1, in2, in3}, 3'd5);
    tick(1'b1, 1'b0, 1'b0, 3'd0);
    idle(3);
    chk("restart_pre", {in1, in2, in3}, 3'd5);
    idle(1);
    chk("restart_sel", {in1, in2, in3}, 3'd6);

    // Jump at terminal count pre-empts the step
    tick(1'b0, 1'b0, 1'b1, 3'd2);
    idle(3);
    tick(1'b0, 1'b0, 1'b1, 3'd6);
    chk("jump_sel", {in1, in2, in3}, 3'd6);
    chk("jump_ack", {2'b00, jump_ack}, 3'd1);
    chk("jump_nowrap", {2'b00, wrap}, 3'd0);
    idle(1);
    chk("jump_ack_drop", {2'b00, jump_ack}, 3'd0);
    idle(2);
    chk("jump_dwell", {in1, in2, in3}, 3'd6);
    idle(1);
    chk("jump_next", {in1, in2, in3}, 3'd7);
    tick(1'b0, 1'b1, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 1'b1, 3'd4);
    chk("idle_jump_sel",  {in1, in2, in3}, 3'd4);
    chk("idle_jump_busy", {2'b00, busy},   3'd0);

    // Collisions: stop+jump, reset mid-run
    tick(1'b1, 1'b0, 1'b0, 3'd0);
    idle(1);
    tick(1'b0, 1'b1, 1'b1, 3'd1);
    chk("coll_sel",  {in1, in2, in3},   3'd4);
    chk("coll_ack",  {2'b00, jump_ack}, 3'd0);
    chk("coll_busy", {2'b00, busy},     3'd0);
    tick(1'b1, 1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 1'b1, 3'd6);
    idle(1);
    sys_rst_n = 1'b0;
    idle(1);
    chk("rst_sel",  {in1, in2, in3}, 3'd0);
    chk("rst_busy", {2'b00, busy},   3'd0);
    sys_rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      dir       = 1'($urandom_range(0, 1));
      sys_rst_n = ($urandom_range(0, 149) != 0);
      tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 14) == 0), 3'($urandom_range(0, 7)));
    end
    sys_rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
